trigger_pulse_generator: RTL and testbench

Transmit side of the DIO trigger path. It produces a programmable trigger pulse train on one DIO output line, so that a counter-delayed trigger receiver on this board or a peer board can lock onto it. The block is armed by software and starts after a delay. It emits a burst of pulses or a continuous train, and reports its armed state and pulse count over AXI-lite status registers.

---
 rtl/trigger_gen_pkg.sv | 41 ++++
 rtl/trigger_gen_timer.sv | 28 ++
 rtl/trigger_pulse_generator.sv | 191 +++++++++++++++++++
 tb/tb_trigger_pulse_generator.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_gen_pkg.sv
// Shared types and helpers for the DIO trigger pulse generator.
// Holds the FSM state encoding, default widths and the effective
// width/period computation used when a sequence is armed.
package trigger_gen_pkg;

   localparam int unsigned TRIG_CNT_W_DEFAULT = 32;
   localparam int unsigned BURST_W_DEFAULT    = 16;

   // Helper arithmetic is done at a fixed wide size; counter widths up to 63 bits are supported.
   localparam int unsigned CALC_W = 64;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DELAY = 3'd1,
      HIGH  = 3'd2,
      LOW   = 3'd3,
      DONE  = 3'd4
   } trig_state_t;

   // A zero pulse width still produces a one-clock pulse.
   function automatic logic [CALC_W-1:0] eff_width(input logic [CALC_W-1:0] pw);
      return (pw == '0) ? CALC_W'(1) : pw;
   endfunction

   // Period is at least W+1 so every pulse has a low phase; an all-ones W pins P at all-ones.
   function automatic logic [CALC_W-1:0] eff_period(input logic [CALC_W-1:0] per,
                                                    input logic [CALC_W-1:0] w,
                                                    input int unsigned       width);
      logic [CALC_W-1:0] ones;
      logic [CALC_W:0]   w_plus1;
      ones    = (CALC_W'(1) << width) - CALC_W'(1);
      w_plus1 = {1'b0, w} + (CALC_W + 1)'(1);
      if (w == ones)
         return ones;
      else if ({1'b0, per} < w_plus1)
         return w_plus1[CALC_W-1:0];
      else
         return per;
   endfunction

endpackage

// File: rtl/trigger_gen_timer.sv
// Loadable down-counter used for the delay, high and low phases.
// Load takes priority over counting; the count stops at zero.
module trigger_gen_timer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   input  logic             en,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // Load a new phase length or count down toward zero.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)
         count <= '0;
      else if (load)
         count <= value;
      else if (en && (count != '0))
         count <= count - WIDTH'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/trigger_pulse_generator.sv
// Programmable DIO trigger pulse train generator (transmit side).
// Armed by software, waits a delay, then emits a burst or a continuous
// train of pulses with registered outputs.
// Optional: define TRIGGER_GEN_TIMESTAMP_EN to add a free-running
// timestamp counter and the last_timestamp output.
module trigger_pulse_generator
   import trigger_gen_pkg::*;
#(
   parameter int unsigned TRIGGER_COUNTER_WIDTH = TRIG_CNT_W_DEFAULT,
   parameter int unsigned BURST_WIDTH           = BURST_W_DEFAULT
) (
   input  logic                             clk,
   input  logic                             aresetn,
   input  logic                             enable,
   input  logic                             arm,
   input  logic                             trigger_reset,
   input  logic [TRIGGER_COUNTER_WIDTH-1:0] period,
   input  logic [TRIGGER_COUNTER_WIDTH-1:0] pulse_width,
   input  logic [TRIGGER_COUNTER_WIDTH-1:0] delay,
   input  logic [BURST_WIDTH-1:0]           burst_count,
`ifdef TRIGGER_GEN_TIMESTAMP_EN
   output logic [TRIGGER_COUNTER_WIDTH-1:0] last_timestamp,
`endif
   output logic                             dio_out,
   output logic                             armed_status,
   output logic                             done_status,
   output logic [BURST_WIDTH-1:0]           pulse_counter
);

   localparam int unsigned TW = TRIGGER_COUNTER_WIDTH;
   localparam logic [TW-1:0] ONE_T = TW'(1);

   trig_state_t            state;
   logic [TW-1:0]          cfg_period;
   logic [TW-1:0]          cfg_width;
   logic [BURST_WIDTH-1:0] cfg_burst;
   logic [BURST_WIDTH-1:0] seq_count;

   logic [CALC_W-1:0]      w_ext;
   logic [CALC_W-1:0]      p_ext;
   logic [TW-1:0]          eff_w;
   logic [TW-1:0]          eff_p;
   logic [TW-1:0]          w_load;
   logic [TW-1:0]          low_load;
   logic                   burst_done;
   logic                   hi_entry;
   logic                   unused_calc_hi;

   logic                   tmr_load;
   logic [TW-1:0]          tmr_value;
   logic                   tmr_en;
   logic                   tmr_zero;

   assign w_ext          = eff_width(CALC_W'(cfg_width));
   assign p_ext          = eff_period(CALC_W'(cfg_period), w_ext, TW);
   assign eff_w          = w_ext[TW-1:0];
   assign eff_p          = p_ext[TW-1:0];
   assign unused_calc_hi = ^{w_ext[CALC_W-1:TW], p_ext[CALC_W-1:TW]};
   assign w_load         = eff_w - ONE_T;
   assign low_load       = (eff_p > eff_w) ? (eff_p - eff_w - ONE_T) : '0;
   assign burst_done     = (cfg_burst != '0) && (seq_count == cfg_burst);
   assign hi_entry       = enable && !trigger_reset && tmr_zero &&
                           ((state == DELAY) || ((state == LOW) && !burst_done));

   // Select which phase length to load into the timer on each transition.
   always_comb begin
      tmr_load  = 1'b0;
      tmr_value = '0;
      tmr_en    = 1'b0;
      if (enable && !trigger_reset) begin
         case (state)
            IDLE: begin
               if (arm) begin
                  tmr_load  = 1'b1;
                  tmr_value = delay;
               end
            end
            DELAY, LOW: begin
               tmr_en = 1'b1;
               if (hi_entry) begin
                  tmr_load  = 1'b1;
                  tmr_value = w_load;
               end
            end
            HIGH: begin
               tmr_en = 1'b1;
               if (tmr_zero) begin
                  tmr_load  = 1'b1;
                  tmr_value = low_load;
               end
            end
            default: ;
         endcase
      end
   end

   trigger_gen_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk     (clk),
      .aresetn (aresetn),
      .load    (tmr_load),
      .value   (tmr_value),
      .en      (tmr_en),
      .zero    (tmr_zero)
   );

   // Sequence FSM with registered trigger output and status flags.
   // The delay input goes straight into the timer on the arm edge, so it needs no separate latch.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= IDLE;
         dio_out       <= 1'b0;
         armed_status  <= 1'b0;
         done_status   <= 1'b0;
         pulse_counter <= '0;
         seq_count     <= '0;
         cfg_period    <= '0;
         cfg_width     <= '0;
         cfg_burst     <= '0;
      end else if (trigger_reset) begin
         state         <= IDLE;
         dio_out       <= 1'b0;
         armed_status  <= 1'b0;
         done_status   <= 1'b0;
         pulse_counter <= '0;
      end else if (!enable) begin
         state        <= IDLE;
         dio_out      <= 1'b0;
         armed_status <= 1'b0;
         done_status  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arm) begin
                  cfg_period   <= period;
                  cfg_width    <= pulse_width;
                  cfg_burst    <= burst_count;
                  seq_count    <= '0;
                  state        <= DELAY;
                  armed_status <= 1'b1;
               end
            end
            DELAY, LOW: begin
               if (hi_entry) begin
                  state   <= HIGH;
                  dio_out <= 1'b1;
                  if (pulse_counter != '1)
                     pulse_counter <= pulse_counter + BURST_WIDTH'(1);
                  if (seq_count != '1)
                     seq_count <= seq_count + BURST_WIDTH'(1);
               end else if (tmr_zero && (state == LOW)) begin
                  state        <= DONE;
                  armed_status <= 1'b0;
                  done_status  <= 1'b1;
               end
            end
            HIGH: begin
               if (tmr_zero) begin
                  state   <= LOW;
                  dio_out <= 1'b0;
               end
            end
            DONE: ;
            default: begin
               state        <= IDLE;
               dio_out      <= 1'b0;
               armed_status <= 1'b0;
               done_status  <= 1'b0;
            end
         endcase
      end
   end

`ifdef TRIGGER_GEN_TIMESTAMP_EN
   logic [TW-1:0] ts;

   // Free-running timestamp; captured on every pulse rising edge.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         ts             <= '0;
         last_timestamp <= '0;
      end else begin
         ts <= ts + ONE_T;
         if (hi_entry)
            last_timestamp <= ts;
      end
   end
`endif

endmodule

// File: tb/tb_trigger_pulse_generator.sv
// Directed self-checking bench for trigger_pulse_generator.
// Define TRIGGER_GEN_TIMESTAMP_EN for both files to cover the timestamp output.
module tb_trigger_pulse_generator;

   logic        clk = 1'b0;
   logic        aresetn;
   logic        enable;
   logic        arm;
   logic        trigger_reset;
   logic [31:0] period;
   logic [31:0] pulse_width;
   logic [31:0] delay;
   logic [15:0] burst_count;
   logic        dio_out;
   logic        armed_status;
   logic        done_status;
   logic [15:0] pulse_counter;
`ifdef TRIGGER_GEN_TIMESTAMP_EN
   logic [31:0] last_timestamp;
   logic [31:0] tb_ts;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   trigger_pulse_generator #(
      .TRIGGER_COUNTER_WIDTH (32),
      .BURST_WIDTH           (16)
   ) dut (
      .clk            (clk),
      .aresetn        (aresetn),
      .enable         (enable),
      .arm            (arm),
      .trigger_reset  (trigger_reset),
      .period         (period),
      .pulse_width    (pulse_width),
      .delay          (delay),
      .burst_count    (burst_count),
`ifdef TRIGGER_GEN_TIMESTAMP_EN
      .last_timestamp (last_timestamp),
`endif
      .dio_out        (dio_out),
      .armed_status   (armed_status),
      .done_status    (done_status),
      .pulse_counter  (pulse_counter)
   );

`ifdef TRIGGER_GEN_TIMESTAMP_EN
   always @(posedge clk or negedge aresetn) begin
      if (!aresetn) tb_ts <= 32'd0;
      else          tb_ts <= tb_ts + 32'd1;
   end
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Arm for exactly one edge (edge N); returns 1 time unit after edge N.
   task automatic pulse_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic clear_block();
      trigger_reset = 1'b1;
      step();
      trigger_reset = 1'b0;
      tests++;
      if (pulse_counter !== 16'd0 || armed_status !== 1'b0 || done_status !== 1'b0) begin
         $display("FAIL clear_block: pc=%0d armed=%b done=%b, want 0/0/0",
                  pulse_counter, armed_status, done_status);
         fails++;
      end
   endtask

   task automatic test_reset();
      #2;
      tests++;
      if (dio_out !== 1'b0 || armed_status !== 1'b0 || done_status !== 1'b0 || pulse_counter !== 16'd0) begin
         $display("FAIL reset_initial: dio=%b armed=%b done=%b pc=%0d, want all 0",
                  dio_out, armed_status, done_status, pulse_counter);
         fails++;
      end
      #20 aresetn = 1'b1;
      step();
      delay = 32'd0; pulse_width = 32'd3; period = 32'd10; burst_count = 16'd0;
      pulse_arm();
      step();
      tests++;
      if (dio_out !== 1'b1 || armed_status !== 1'b1 || pulse_counter !== 16'd1) begin
         $display("FAIL reset_prepulse: dio=%b armed=%b pc=%0d, want 1/1/1",
                  dio_out, armed_status, pulse_counter);
         fails++;
      end
      #2 aresetn = 1'b0;
      #1;
      tests++;
      if (dio_out !== 1'b0 || armed_status !== 1'b0 || done_status !== 1'b0 || pulse_counter !== 16'd0) begin
         $display("FAIL reset_midpulse: dio=%b armed=%b done=%b pc=%0d, want all 0",
                  dio_out, armed_status, done_status, pulse_counter);
         fails++;
      end
      @(negedge clk);
      aresetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         tests++;
         if (dio_out !== 1'b0 || armed_status !== 1'b0) begin
            $display("FAIL reset_idle: dio=%b armed=%b, want 0/0", dio_out, armed_status);
            fails++;
         end
      end
   endtask

   task automatic test_burst();
      logic        exp_dio;
      logic        exp_armed;
      logic        exp_done;
      logic [15:0] exp_pc;
      delay = 32'd10; pulse_width = 32'd5; period = 32'd25; burst_count = 16'd3;
      pulse_arm();
      for (int e = 1; e <= 95; e++) begin
         step();
         exp_dio   = (e >= 11 && e < 16) || (e >= 36 && e < 41) || (e >= 61 && e < 66);
         exp_armed = (e < 86);
         exp_done  = (e >= 86);
         exp_pc    = 16'((e >= 11) + (e >= 36) + (e >= 61));
         tests++;
         if (dio_out !== exp_dio || armed_status !== exp_armed ||
             done_status !== exp_done || pulse_counter !== exp_pc) begin
            $display("FAIL burst e=%0d: dio=%b armed=%b done=%b pc=%0d, want %b %b %b %0d",
                     e, dio_out, armed_status, done_status, pulse_counter,
                     exp_dio, exp_armed, exp_done, exp_pc);
            fails++;
         end
      end
   endtask

   task automatic test_reset_in_done();
      arm = 1'b1;
      trigger_reset = 1'b1;
      step();
      arm = 1'b0;
      trigger_reset = 1'b0;
      tests++;
      if (done_status !== 1'b0 || armed_status !== 1'b0 || pulse_counter !== 16'd0 || dio_out !== 1'b0) begin
         $display("FAIL done_reset: done=%b armed=%b pc=%0d dio=%b, want 0 0 0 0",
                  done_status, armed_status, pulse_counter, dio_out);
         fails++;
      end
      for (int i = 0; i < 20; i++) begin
         step();
         tests++;
         if (dio_out !== 1'b0 || armed_status !== 1'b0) begin
            $display("FAIL done_reset_quiet: dio=%b armed=%b, want 0/0", dio_out, armed_status);
            fails++;
         end
      end
      pulse_arm();
      for (int e = 1; e <= 15; e++) begin
         step();
         tests++;
         if (dio_out !== (e >= 11) || armed_status !== 1'b1 || pulse_counter !== 16'(e >= 11)) begin
            $display("FAIL rearm e=%0d: dio=%b armed=%b pc=%0d, want %b 1 %0d",
                     e, dio_out, armed_status, pulse_counter, (e >= 11), (e >= 11));
            fails++;
         end
      end
      clear_block();
   endtask

   task automatic test_continuous();
      logic        exp_dio;
      logic [15:0] exp_pc;
      delay = 32'd2; pulse_width = 32'd4; period = 32'd4; burst_count = 16'd0;
      pulse_arm();
      period = 32'd100;
      pulse_width = 32'd1;
      for (int e = 1; e <= 30; e++) begin
         step();
         exp_dio = (e >= 3) && (((e - 3) % 5) < 4);
         exp_pc  = (e < 3) ? 16'd0 : 16'((e - 3) / 5 + 1);
         tests++;
         if (dio_out !== exp_dio || pulse_counter !== exp_pc || armed_status !== 1'b1) begin
            $display("FAIL continuous e=%0d: dio=%b pc=%0d armed=%b, want %b %0d 1",
                     e, dio_out, pulse_counter, armed_status, exp_dio, exp_pc);
            fails++;
         end
      end
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         tests++;
         if (dio_out !== 1'b0 || armed_status !== 1'b0 || pulse_counter !== 16'd6) begin
            $display("FAIL disable i=%0d: dio=%b armed=%b pc=%0d, want 0 0 6",
                     i, dio_out, armed_status, pulse_counter);
            fails++;
         end
      end
      enable = 1'b1;
      clear_block();
   endtask

   task automatic test_min_pulse();
      delay = 32'd0; pulse_width = 32'd0; period = 32'd1; burst_count = 16'd1;
      pulse_arm();
      for (int e = 1; e <= 4; e++) begin
         step();
         tests++;
         if (dio_out !== (e == 1) || done_status !== (e >= 3) || pulse_counter !== 16'd1) begin
            $display("FAIL min_pulse e=%0d: dio=%b done=%b pc=%0d, want %b %b 1",
                     e, dio_out, done_status, pulse_counter, (e == 1), (e >= 3));
            fails++;
         end
      end
      for (int k = 0; k < 3; k++) begin
         pulse_arm();
         for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (dio_out !== 1'b0 || done_status !== 1'b1 || armed_status !== 1'b0 || pulse_counter !== 16'd1) begin
               $display("FAIL done_ignores_arm: dio=%b done=%b armed=%b pc=%0d, want 0 1 0 1",
                        dio_out, done_status, armed_status, pulse_counter);
               fails++;
            end
         end
      end
      clear_block();
   endtask

`ifdef TRIGGER_GEN_TIMESTAMP_EN
   task automatic test_timestamp();
      logic        prev_dio;
      logic [31:0] prev_ts;
      int          rises;
      delay = 32'd3; pulse_width = 32'd2; period = 32'd7; burst_count = 16'd3;
      prev_dio = 1'b0;
      prev_ts  = 32'd0;
      rises    = 0;
      pulse_arm();
      for (int e = 1; e <= 30; e++) begin
         step();
         if (dio_out === 1'b1 && prev_dio === 1'b0) begin
            tests++;
            if (last_timestamp !== tb_ts - 32'd1) begin
               $display("FAIL ts_value: got %0d, want %0d", last_timestamp, tb_ts - 32'd1);
               fails++;
            end
            if (rises > 0) begin
               tests++;
               if (last_timestamp - prev_ts !== 32'd7) begin
                  $display("FAIL ts_delta: got %0d, want 7", last_timestamp - prev_ts);
                  fails++;
               end
            end
            prev_ts = last_timestamp;
            rises++;
         end
         prev_dio = dio_out;
      end
      tests++;
      if (rises != 3) begin
         $display("FAIL ts_rises: got %0d, want 3", rises);
         fails++;
      end
      clear_block();
   endtask
`endif

   initial begin
      aresetn       = 1'b0;
      enable        = 1'b1;
      arm           = 1'b0;
      trigger_reset = 1'b0;
      period        = 32'd0;
      pulse_width   = 32'd0;
      delay         = 32'd0;
      burst_count   = 16'd0;
      test_reset();
      test_burst();
      test_reset_in_done();
      test_continuous();
      test_min_pulse();
`ifdef TRIGGER_GEN_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
